// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch controller bus: buttons and BCD counter values in, counter pulses and display out.
// master = controller side, slave = counters/display side; no backpressure on any signal.
interface stopwatch_ctrl_if;
  logic        ss;
  logic        lr;
  logic [3:0]  sec_tens;
  logic [3:0]  sec_ones;
  logic [3:0]  min_tens;
  logic [3:0]  min_ones;
  logic        sec_inc;
  logic        min_inc;
  logic        cnt_clr;
  logic [15:0] disp;
  logic [1:0]  state;
  logic        ovf;

  modport master (
    input  ss, lr, sec_tens, sec_ones, min_tens, min_ones,
    output sec_inc, min_inc, cnt_clr, disp, state, ovf
  );

  modport slave (
    output ss, lr, sec_tens, sec_ones, min_tens, min_ones,
    input  sec_inc, min_inc, cnt_clr, disp, state, ovf
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch FSM with a DIV-cycle prescaler driving external BCD counters; all outputs registered.
// Latency: press to state change and display update is 1 cycle; no backpressure, pulses are fire-and-forget.
module stopwatch_ctrl #(
  parameter int DIV = 10
) (
  input  logic             clk,
  input  logic             rs,
  stopwatch_ctrl_if.master sw
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          ss_q, ss_d;
  logic          lr_q, lr_d;
  logic          sec_inc_q, sec_inc_d;
  logic          min_inc_q, min_inc_d;
  logic          cnt_clr_q, cnt_clr_d;
  logic [15:0]   disp_q, disp_d;
  logic          ovf_q, ovf_d;

  logic          ss_rise;
  logic          lr_rise;
  logic          timing_q;
  logic          timing_d;
  logic          tick;
  logic          sec_at_59;
  logic          min_at_59;
  logic [15:0]   live_bcd;

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      ss_q      <= 1'b0;
      lr_q      <= 1'b0;
      sec_inc_q <= 1'b0;
      min_inc_q <= 1'b0;
      cnt_clr_q <= 1'b0;
      disp_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      ss_q      <= ss_d;
      lr_q      <= lr_d;
      sec_inc_q <= sec_inc_d;
      min_inc_q <= min_inc_d;
      cnt_clr_q <= cnt_clr_d;
      disp_q    <= disp_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    ss_d      = sw.ss;
    lr_d      = sw.lr;
    ss_rise   = sw.ss & ~ss_q;
    // start/stop wins; a coincident lap/reset press is dropped
    lr_rise   = sw.lr & ~lr_q & ~ss_rise;
    sec_at_59 = (sw.sec_tens == 4'd5) && (sw.sec_ones == 4'd9);
    min_at_59 = (sw.min_tens == 4'd5) && (sw.min_ones == 4'd9);
    live_bcd  = {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones};

    state_d = state_q;
    case (state_q)
      IDLE:    if (ss_rise) state_d = RUN;
      RUN:     if (ss_rise) state_d = PAUSE; else if (lr_rise) state_d = LAP;
      LAP:     if (ss_rise) state_d = PAUSE; else if (lr_rise) state_d = RUN;
      PAUSE:   if (ss_rise) state_d = RUN;   else if (lr_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The prescaler only advances on edges that stay within RUN/LAP, so a
    // pause freezes the partial second exactly where it was pressed.
    timing_q = (state_q == RUN) || (state_q == LAP);
    timing_d = (state_d == RUN) || (state_d == LAP);
    pre_d    = pre_q;
    tick     = 1'b0;
    if (state_d == IDLE) begin
      pre_d = '0;
    end else if (timing_q && timing_d) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        tick  = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end

    sec_inc_d = tick;
    min_inc_d = tick && sec_at_59;
    cnt_clr_d = (state_q == PAUSE) && (state_d == IDLE);

    ovf_d = ovf_q;
    if (cnt_clr_d) ovf_d = 1'b0;
    else if (tick && sec_at_59 && min_at_59) ovf_d = 1'b1;

    // The RUN->LAP edge samples live values; while in LAP the snapshot holds.
    disp_d = (state_q == LAP) ? disp_q : live_bcd;
  end

  assign sw.sec_inc = sec_inc_q;
  assign sw.min_inc = min_inc_q;
  assign sw.cnt_clr = cnt_clr_q;
  assign sw.disp    = disp_q;
  assign sw.state   = state_q;
  assign sw.ovf     = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl at DIV=4: inputs driven 1 time unit after each
// rising edge, outputs sampled there too, against hand-computed expectations.
module tb_stopwatch_ctrl;

  logic clk;
  logic rs;
  int   checks;
  int   failures;
  int   pulses;

  stopwatch_ctrl_if sw ();

  stopwatch_ctrl #(.DIV(4)) dut (
    .clk (clk),
    .rs  (rs),
    .sw  (sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_bcd(input logic [15:0] v);
    sw.min_tens = v[15:12];
    sw.min_ones = v[11:8];
    sw.sec_tens = v[7:4];
    sw.sec_ones = v[3:0];
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rs       = 1'b0;
    sw.ss    = 1'b0;
    sw.lr    = 1'b0;
    set_bcd(16'h0000);

    // reset state, before any clock edge
    #2;
    check("rst_state",   32'(sw.state),   32'd0);
    check("rst_disp",    32'(sw.disp),    32'd0);
    check("rst_sec_inc", 32'(sw.sec_inc), 32'd0);
    check("rst_min_inc", 32'(sw.min_inc), 32'd0);
    check("rst_cnt_clr", 32'(sw.cnt_clr), 32'd0);
    check("rst_ovf",     32'(sw.ovf),     32'd0);
    step(2);

    // IDLE -> RUN, tick on the 4th edge after entry and every 4 thereafter
    rs    = 1'b1;
    sw.ss = 1'b1;
    step(1);
    check("run_entry_state", 32'(sw.state), 32'd1);
    sw.ss = 1'b0;
    step(3);
    check("tick_not_early", 32'(sw.sec_inc), 32'd0);
    step(1);
    check("tick_first", 32'(sw.sec_inc), 32'd1);
    step(1);
    check("tick_one_cycle", 32'(sw.sec_inc), 32'd0);
    step(3);
    check("tick_second", 32'(sw.sec_inc), 32'd1);
    check("tick_no_min", 32'(sw.min_inc), 32'd0);

    // seconds at 59 -> minute carry; 59:59 -> sticky overflow
    set_bcd(16'h1259);
    step(4);
    check("carry_sec_inc", 32'(sw.sec_inc), 32'd1);
    check("carry_min_inc", 32'(sw.min_inc), 32'd1);
    check("carry_no_ovf",  32'(sw.ovf),     32'd0);
    set_bcd(16'h5959);
    step(4);
    check("ovf_min_inc", 32'(sw.min_inc), 32'd1);
    check("ovf_set",     32'(sw.ovf),     32'd1);
    set_bcd(16'h0000);
    step(4);
    check("ovf_sticky",     32'(sw.ovf),     32'd1);
    check("wrap_no_min",    32'(sw.min_inc), 32'd0);
    check("disp_live_zero", 32'(sw.disp),    32'h0000);

    // lap freeze while the prescaler keeps running
    set_bcd(16'h0327);
    sw.lr = 1'b1;
    step(1);
    check("lap_state",   32'(sw.state), 32'd3);
    check("lap_capture", 32'(sw.disp),  32'h0327);
    sw.lr = 1'b0;
    set_bcd(16'h0328);
    step(1);
    check("lap_frozen", 32'(sw.disp), 32'h0327);
    step(2);
    check("lap_tick_continues", 32'(sw.sec_inc), 32'd1);
    sw.lr = 1'b1;
    step(1);
    check("lap_exit_state", 32'(sw.state), 32'd1);
    check("lap_exit_hold",  32'(sw.disp),  32'h0327);
    sw.lr = 1'b0;
    step(1);
    check("lap_exit_live", 32'(sw.disp), 32'h0328);

    // pause with pre=2: no ticks; resume ticks after 2 edges
    sw.ss = 1'b1;
    step(1);
    check("pause_state", 32'(sw.state), 32'd2);
    sw.ss  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (sw.sec_inc) pulses++;
    end
    check("pause_no_tick", 32'(pulses), 32'd0);
    sw.ss = 1'b1;
    step(1);
    check("resume_state", 32'(sw.state),   32'd1);
    check("resume_edge0", 32'(sw.sec_inc), 32'd0);
    sw.ss = 1'b0;
    step(1);
    check("resume_edge1", 32'(sw.sec_inc), 32'd0);
    step(1);
    check("resume_edge2", 32'(sw.sec_inc), 32'd1);

    // simultaneous ss+lr in RUN: only start/stop acts
    sw.ss = 1'b1;
    sw.lr = 1'b1;
    step(1);
    check("both_to_pause", 32'(sw.state), 32'd2);
    sw.ss = 1'b0;
    sw.lr = 1'b0;
    step(1);
    check("both_stay_pause", 32'(sw.state), 32'd2);
    check("ovf_before_clr",  32'(sw.ovf),   32'd1);

    // PAUSE -> IDLE clears counters and overflow
    sw.lr = 1'b1;
    step(1);
    check("clr_state", 32'(sw.state),   32'd0);
    check("clr_pulse", 32'(sw.cnt_clr), 32'd1);
    check("clr_ovf",   32'(sw.ovf),     32'd0);
    sw.lr = 1'b0;
    pulses = 0;
    step(1);
    check("clr_one_cycle", 32'(sw.cnt_clr), 32'd0);
    for (int i = 0; i < 6; i++) begin
      if (sw.sec_inc || sw.min_inc) pulses++;
      step(1);
    end
    check("idle_no_tick", 32'(pulses), 32'd0);
    sw.lr = 1'b1;
    step(1);
    check("idle_lr_holds", 32'(sw.state), 32'd0);
    sw.lr = 1'b0;

    // reset mid-RUN at pre=3, start button held through release
    set_bcd(16'h1234);
    sw.ss = 1'b1;
    step(1);
    sw.ss = 1'b0;
    step(3);
    check("pre_rst_disp",  32'(sw.disp),  32'h1234);
    check("pre_rst_state", 32'(sw.state), 32'd1);
    #2;
    rs    = 1'b0;
    sw.ss = 1'b1;
    #1;
    check("async_rst_state", 32'(sw.state),   32'd0);
    check("async_rst_disp",  32'(sw.disp),    32'd0);
    check("async_rst_sec",   32'(sw.sec_inc), 32'd0);
    step(2);
    rs = 1'b1;
    step(1);
    check("held_ss_run",      32'(sw.state),   32'd1);
    check("no_pending_tick",  32'(sw.sec_inc), 32'd0);
    step(3);
    check("fresh_pre_early", 32'(sw.sec_inc), 32'd0);
    step(1);
    check("fresh_pre_tick",  32'(sw.sec_inc), 32'd1);
    sw.ss = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 10: clk cycles per one-second tick (legal range 2..2^26).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rs  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ss  input  1  start/stop button, clk-synchronous level.
REQ-005 SHALL have port lr  input  1  lap/reset button, clk-synchronous level.
REQ-006 SHALL have ports sec_tens, sec_ones, min_tens, min_ones  input  4 each  BCD value of the external mod-60 seconds and minutes counters.
REQ-007 SHALL have port sec_inc  output  1  one-cycle increment pulse to the seconds counter.
REQ-008 SHALL have port min_inc  output  1  one-cycle increment pulse to the minutes counter.
REQ-009 SHALL have port cnt_clr  output  1  one-cycle synchronous clear pulse to both counters.
REQ-010 SHALL have port disp  output  16  {min_tens,min_ones,sec_tens,sec_ones} for the display.
REQ-011 SHALL have port state  output  2  FSM state: IDLE=00, RUN=01, PAUSE=10, LAP=11.
REQ-012 SHALL have port ovf  output  1  sticky 59:59 rollover flag.

Function
REQ-013 SHALL detect a press as a rising edge: input 1 this edge, 0 at the previous edge (one register per button).
REQ-014 SHALL give ss priority when ss and lr rising edges coincide; the lr edge is discarded.
REQ-015 SHALL transition, on the edge where the press is detected: IDLE -ss-> RUN; RUN -ss-> PAUSE; RUN -lr-> LAP; LAP -ss-> PAUSE; LAP -lr-> RUN; PAUSE -ss-> RUN; PAUSE -lr-> IDLE; all other press/state combinations hold state.
REQ-016 SHALL assert cnt_clr for exactly the one cycle following the PAUSE->IDLE transition edge.
REQ-017 SHALL keep prescaler counter pre at 0 in IDLE, increment it by 1 per cycle in RUN and LAP, and hold it in PAUSE.
REQ-018 SHALL, when pre==DIV-1 in RUN or LAP, wrap pre to 0 and assert sec_inc for the following cycle only.
REQ-019 SHALL assert min_inc in the same cycle as sec_inc iff sec_tens==5 and sec_ones==9 at the tick edge.
REQ-020 SHALL set ovf on the tick edge when sec and min inputs both equal 59; ovf clears only on cnt_clr or reset.
REQ-021 SHALL register disp from the four BCD inputs every cycle (1-cycle latency) in IDLE, RUN, PAUSE.
REQ-022 SHALL, on the RUN->LAP edge, capture disp from current inputs and hold it frozen throughout LAP; on leaving LAP disp resumes live update on the next edge.
REQ-023 SHALL not alter pre on RUN<->LAP transitions (timing continues uninterrupted).
REQ-024 SHALL assert no sec_inc/min_inc from the PAUSE->IDLE edge until the next RUN entry.
REQ-025 SHALL produce sec_inc, min_inc, cnt_clr, state, disp, ovf directly from registers (no combinational input-to-output paths).

Reset
REQ-026 SHALL, while rs==0, force state=IDLE, pre=0, sec_inc=0, min_inc=0, cnt_clr=0, disp=0, ovf=0, button edge registers=0, independent of clk.
REQ-027 SHALL treat a button held high across reset release as a press on the first clk edge after release.
REQ-028 SHALL, on reset mid-RUN or mid-LAP, abandon any pending tick; no pulse follows reset release.

Verification (DIV=4)
REQ-029 Reset, ss press -> state=01; sec_inc pulses every 4 cycles, first on the 4th cycle after entering RUN.
REQ-030 RUN with inputs sec=5,9 min=1,2 at tick -> sec_inc=1 and min_inc=1 same cycle; inputs 59:59 at tick -> ovf=1, stays 1.
REQ-031 RUN, pre=2, ss press -> PAUSE, no sec_inc for 20 cycles; ss again -> first sec_inc 2 cycles after RUN re-entry.
REQ-032 RUN, inputs 03:27, lr press -> state=11, disp=16'h0327 held while inputs advance; lr again -> state=01, disp tracks inputs next cycle.
REQ-033 PAUSE, lr press -> state=00, cnt_clr=1 for one cycle, ovf=0; simultaneous ss+lr in RUN -> PAUSE only.
REQ-034 rs low mid-RUN with pre=3 -> all outputs 0 immediately, no sec_inc after release; ss held through release -> RUN on first edge.
